// File: rtl/audio_pkg.sv
// Shared constants and types for the I2S transmitter slice.
package audio_pkg;

    localparam int unsigned FRAME_BITS   = 32;
    localparam int unsigned SAMPLE_W     = 16;
    localparam int unsigned FIFO_LEVEL_W = 5;

    typedef logic [FRAME_BITS-1:0]   frame_word_t;
    typedef logic [FIFO_LEVEL_W-1:0] fifo_level_t;

    // Word select for a given bit slot: right channel covers slots 15..30, so
    // LRCLK leads each channel's MSB by one BCLK.
    function automatic logic ws_for_bit(input logic [4:0] b);
        return (b >= 5'd15) && (b <= 5'd30);
    endfunction

endpackage

// File: rtl/audio_i2s_tx_if.sv
// Sample write port: one strobe carries a left/right pair into the FIFO.
interface audio_i2s_tx_if;
    import audio_pkg::*;

    logic signed [SAMPLE_W-1:0] sample_l;
    logic signed [SAMPLE_W-1:0] sample_r;
    logic                       sample_valid;

    modport master (output sample_l, output sample_r, output sample_valid);
    modport slave  (input  sample_l, input  sample_r, input  sample_valid);

endinterface

// File: rtl/audio_sample_fifo.sv
// Stereo sample FIFO: power-of-two depth, write accepted when full if a read
// happens in the same cycle.
module audio_sample_fifo
    import audio_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr,
    input  frame_word_t wr_data,
    input  logic        rd,
    output frame_word_t rd_data,
    output logic        full,
    output logic        empty,
    output fifo_level_t level
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    frame_word_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    fifo_level_t      level_q;
    logic             do_rd;
    logic             do_wr;

    assign empty   = (level_q == '0);
    assign full    = (level_q == FIFO_LEVEL_W'(DEPTH));
    assign level   = level_q;
    assign rd_data = mem[rd_ptr_q];
    assign do_rd   = rd && !empty;
    assign do_wr   = wr && (!full || do_rd);

    // Storage array; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({do_wr, do_rd})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S transmitter: sample FIFO, BCLK divider and 32-slot frame serializer.
module audio_i2s_tx
    import audio_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    audio_i2s_tx_if.slave         smp,
    input  logic                  status_clr,
    output logic                  i2s_bclk,
    output logic                  i2s_lrclk,
    output logic                  i2s_sdata,
    output fifo_level_t           fifo_level,
    output logic                  underflow,
    output logic                  overflow
);

    logic [7:0]  div_q;
    logic        bclk_q;
    logic        lrclk_q;
    logic        sdata_q;
    logic [4:0]  bit_q;
    frame_word_t word_q;
    logic        underflow_q;
    logic        overflow_q;

    logic        half_done;
    logic        fall;
    logic        frame_start;
    logic        pop;
    logic        drop;
    logic        uflow_set;
    logic [4:0]  bit_next;
    frame_word_t next_word;
    frame_word_t fifo_rd_data;
    logic        fifo_full;
    logic        fifo_empty;

    audio_sample_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr      (smp.sample_valid),
        .wr_data ({smp.sample_l, smp.sample_r}),
        .rd      (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign half_done   = enable && (div_q == 8'(CLK_DIV - 1));
    assign fall        = half_done && bclk_q;
    assign bit_next    = bit_q + 5'd1;
    assign frame_start = fall && (bit_q == 5'd31);
    assign pop         = frame_start && !fifo_empty;
    // An empty FIFO at frame start replays the previous frame.
    assign next_word   = pop ? fifo_rd_data : word_q;
    assign uflow_set   = frame_start && fifo_empty;
    assign drop        = smp.sample_valid && fifo_full && !pop;

    // BCLK divider: toggle every CLK_DIV cycles while enabled, parked low otherwise.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            div_q  <= '0;
            bclk_q <= 1'b0;
        end else if (half_done) begin
            div_q  <= '0;
            bclk_q <= ~bclk_q;
        end else begin
            div_q  <= div_q + 8'd1;
        end
    end

    // Serializer: slot index, word select and data all advance on BCLK falls.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_q   <= 5'd31;
            lrclk_q <= 1'b0;
            sdata_q <= 1'b0;
            word_q  <= '0;
        end else if (!enable) begin
            bit_q   <= 5'd31;
            lrclk_q <= 1'b0;
            sdata_q <= 1'b0;
        end else if (fall) begin
            bit_q   <= bit_next;
            lrclk_q <= ws_for_bit(bit_next);
            sdata_q <= next_word[5'd31 - bit_next];
            word_q  <= next_word;
        end
    end

    // Sticky status flags; a new event in the clearing cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            underflow_q <= uflow_set | (underflow_q & ~status_clr);
            overflow_q  <= drop | (overflow_q & ~status_clr);
        end
    end

    assign i2s_bclk  = bclk_q;
    assign i2s_lrclk = lrclk_q;
    assign i2s_sdata = sdata_q;
    assign underflow = underflow_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Self-checking bench for audio_i2s_tx: queue-based reference model plus
// directed scenarios and a randomized run; a second instance checks timing.
module tb_audio_i2s_tx;
    import audio_pkg::*;

    localparam int DIV   = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic status_clr = 1'b0;
    logic en_slow = 1'b0;

    logic        dut_bclk, dut_lrclk, dut_sdata, dut_uf, dut_of;
    fifo_level_t dut_level;
    logic        s_bclk, s_lrclk, s_sdata, s_uf, s_of;
    fifo_level_t s_level;

    audio_i2s_tx_if smp_if ();
    audio_i2s_tx_if slow_if ();

    always #5 clk = ~clk;

    audio_i2s_tx #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .smp        (smp_if.slave),
        .status_clr (status_clr),
        .i2s_bclk   (dut_bclk),
        .i2s_lrclk  (dut_lrclk),
        .i2s_sdata  (dut_sdata),
        .fifo_level (dut_level),
        .underflow  (dut_uf),
        .overflow   (dut_of)
    );

    audio_i2s_tx #(.CLK_DIV(8), .FIFO_DEPTH(DEPTH)) dut_slow (
        .clk        (clk),
        .reset      (reset),
        .enable     (en_slow),
        .smp        (slow_if.slave),
        .status_clr (1'b0),
        .i2s_bclk   (s_bclk),
        .i2s_lrclk  (s_lrclk),
        .i2s_sdata  (s_sdata),
        .fifo_level (s_level),
        .underflow  (s_uf),
        .overflow   (s_of)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, BCLK phase and slot derived from the
    // number of enabled cycles since enable rose.
    logic [31:0] m_fifo[$];
    logic [31:0] m_last;
    int          m_ph, m_nfall, m_q;
    logic        m_fell, m_bclk, m_lr, m_sd, m_uf, m_of;
    logic        uf_set, of_set;

    always @(posedge clk) begin
        m_fell = 1'b0;
        if (reset) begin
            m_fifo.delete();
            m_last = '0; m_ph = 0; m_nfall = 0; m_q = 31;
            m_bclk = 0; m_lr = 0; m_sd = 0; m_uf = 0; m_of = 0;
        end else begin
            uf_set = 0;
            of_set = 0;
            if (enable) begin
                if ((m_ph + 1) % (2 * DIV) == 0) begin
                    m_fell = 1'b1;
                    m_nfall++;
                    m_q = (m_nfall - 1) % 32;
                    if (m_q == 0) begin
                        if (m_fifo.size() > 0) m_last = m_fifo.pop_front();
                        else uf_set = 1;
                    end
                    m_sd = m_last[31 - m_q];
                    m_lr = (m_q >= 15) && (m_q <= 30);
                end
                m_bclk = ((m_ph + 1) / DIV) % 2;
                m_ph++;
            end else begin
                m_ph = 0; m_nfall = 0; m_q = 31;
                m_bclk = 0; m_lr = 0; m_sd = 0;
            end
            if (smp_if.sample_valid) begin
                if (m_fifo.size() < DEPTH) m_fifo.push_back({smp_if.sample_l, smp_if.sample_r});
                else of_set = 1;
            end
            m_uf = uf_set | (m_uf & !status_clr);
            m_of = of_set | (m_of & !status_clr);
        end
    end

    // Cycle-by-cycle comparison and frame capture, away from the active edge.
    logic        mon_on = 1'b0;
    int          cap_frame = -1;
    logic [31:0] cap_word, cap_lr;

    always @(negedge clk) begin
        if (mon_on) begin
            check("bclk",  dut_bclk,  m_bclk);
            check("lrclk", dut_lrclk, m_lr);
            check("sdata", dut_sdata, m_sd);
            check("level", dut_level, m_fifo.size());
            check("uflow", dut_uf,    m_uf);
            check("oflow", dut_of,    m_of);
            if (cap_frame >= 0 && m_fell && ((m_nfall - 1) / 32) == cap_frame) begin
                cap_word[31 - m_q] = dut_sdata;
                cap_lr[m_q]        = dut_lrclk;
            end
        end
    end

    // Rising-edge timestamps of the slow instance.
    int cyc = 0;
    logic s_bclk_prev = 1'b0, s_lr_prev = 1'b0;
    int bclk_rise[$];
    int lr_rise[$];

    always @(negedge clk) begin
        cyc++;
        if (s_bclk && !s_bclk_prev) bclk_rise.push_back(cyc);
        if (s_lrclk && !s_lr_prev) lr_rise.push_back(cyc);
        s_bclk_prev = s_bclk;
        s_lr_prev   = s_lrclk;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic write(input logic [15:0] l, input logic [15:0] r);
        smp_if.sample_l     = l;
        smp_if.sample_r     = r;
        smp_if.sample_valid = 1'b1;
        tick(1);
        smp_if.sample_valid = 1'b0;
    endtask

    task automatic clear_flags();
        status_clr = 1'b1;
        tick(1);
        status_clr = 1'b0;
    endtask

    initial begin
        bit found;
        smp_if.sample_l = '0; smp_if.sample_r = '0; smp_if.sample_valid = 1'b0;
        slow_if.sample_l = '0; slow_if.sample_r = '0; slow_if.sample_valid = 1'b0;
        tick(1);
        mon_on = 1'b1;
        tick(2);
        reset = 1'b0;

        // Reset state
        check("rst_bclk", dut_bclk, 0);
        check("rst_lrclk", dut_lrclk, 0);
        check("rst_sdata", dut_sdata, 0);
        check("rst_level", dut_level, 0);
        check("rst_uflow", dut_uf, 0);
        check("rst_oflow", dut_of, 0);

        // Single frame: MSB-first L then R, word select pattern per slot
        write(16'h8001, 16'h7FFE);
        check("a_level", dut_level, 1);
        cap_word = '0; cap_lr = '0; cap_frame = 0;
        enable = 1'b1;
        tick(64 * DIV + 4);
        cap_frame = -1;
        check("a_frame", cap_word, 32'h8001_7FFE);
        check("a_lrclk", cap_lr, 32'h7FFF_8000);
        enable = 1'b0;

        // Five writes into a 4-deep FIFO while idle
        pulse_reset();
        for (int i = 0; i < 5; i++) write(16'($urandom), 16'($urandom));
        check("b_level", dut_level, 4);
        check("b_oflow", dut_of, 1);
        clear_flags();
        check("b_oflow_clr", dut_of, 0);
        enable = 1'b1;
        tick(64 * DIV * 6);
        check("b_uflow", dut_uf, 1);
        enable = 1'b0;

        // One write replayed over several frames
        pulse_reset();
        write(16'h1234, 16'h5678);
        cap_word = '0; cap_frame = 3;
        enable = 1'b1;
        tick(64 * DIV * 4 + 8);
        cap_frame = -1;
        check("c_frame3", cap_word, 32'h1234_5678);
        check("c_uflow", dut_uf, 1);
        enable = 1'b0;
        tick(1);
        clear_flags();
        check("c_uflow_clr", dut_uf, 0);

        // Pop and write in the same cycle with the FIFO full
        pulse_reset();
        for (int i = 0; i < 4; i++) write(16'($urandom), 16'($urandom));
        check("d_level_full", dut_level, 4);
        enable = 1'b1;
        tick(2 * DIV - 1);
        smp_if.sample_l = 16'hCAFE; smp_if.sample_r = 16'hF00D; smp_if.sample_valid = 1'b1;
        tick(1);
        smp_if.sample_valid = 1'b0;
        check("d_level", dut_level, 4);
        check("d_oflow", dut_of, 0);
        tick(64 * DIV * 5);

        // Reset in the middle of a frame
        write(16'h0BAD, 16'hBEEF);
        write(16'h1111, 16'h2222);
        found = 0;
        for (int i = 0; i < 64 * DIV * 2 && !found; i++) begin
            tick(1);
            if (m_fell && m_q == 10) found = 1;
        end
        check("e_reach_bit10", found, 1);
        reset = 1'b1;
        tick(1);
        check("e_bclk", dut_bclk, 0);
        check("e_lrclk", dut_lrclk, 0);
        check("e_sdata", dut_sdata, 0);
        check("e_level", dut_level, 0);
        check("e_uflow", dut_uf, 0);
        check("e_oflow", dut_of, 0);
        cap_word = '1; cap_frame = 0;
        reset = 1'b0;
        tick(64 * DIV + 4);
        cap_frame = -1;
        check("e_frame_zero", cap_word, 0);
        check("e_uflow_after", dut_uf, 1);
        enable = 1'b0;

        // Randomized traffic, enable toggles and flag clears
        pulse_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(299) == 0) enable = ~enable;
            else if (i == 10) enable = 1'b1;
            smp_if.sample_l     = 16'($urandom);
            smp_if.sample_r     = 16'($urandom);
            smp_if.sample_valid = ($urandom_range(39) == 0);
            status_clr          = ($urandom_range(199) == 0);
            tick(1);
        end
        smp_if.sample_valid = 1'b0;
        status_clr = 1'b0;
        enable = 1'b0;

        // Slow instance timing over several frames
        pulse_reset();
        bclk_rise.delete();
        lr_rise.delete();
        en_slow = 1'b1;
        tick(5 * 512 + 20);
        en_slow = 1'b0;
        check("g_lr_rises", (lr_rise.size() >= 4), 1);
        check("g_bclk_rises", (bclk_rise.size() >= 128), 1);
        for (int i = 1; i < bclk_rise.size(); i++)
            check("g_bclk_period", bclk_rise[i] - bclk_rise[i-1], 16);
        for (int i = 1; i < lr_rise.size(); i++)
            check("g_lrclk_period", lr_rise[i] - lr_rise[i-1], 512);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/audio_i2s_tx.md
AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 8, meaning clk cycles per BCLK half-period (legal range 2..255).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning stereo sample FIFO entries (power of two, 2..16).
REQ-003 SHALL have port clk, input, 1, the single system clock.
REQ-004 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port enable, input, 1, serializer run enable.
REQ-006 SHALL have port sample_l, input, 16, signed left sample from the upstream synthesizer.
REQ-007 SHALL have port sample_r, input, 16, signed right sample.
REQ-008 SHALL have port sample_valid, input, 1, a one-cycle strobe that writes {sample_l, sample_r}.
REQ-009 SHALL have port status_clr, input, 1, a one-cycle strobe that clears the sticky flags.
REQ-010 SHALL have port i2s_bclk, output, 1, bit clock.
REQ-011 SHALL have port i2s_lrclk, output, 1, word select (0 = left).
REQ-012 SHALL have port i2s_sdata, output, 1, serial data, MSB first.
REQ-013 SHALL have port fifo_level, output, 5, the current FIFO occupancy.
REQ-014 SHALL have port underflow, output, 1, sticky: a frame started with the FIFO empty.
REQ-015 SHALL have port overflow, output, 1, sticky: a write was dropped because the FIFO was full.

Function
REQ-016 SHALL write on sample_valid when not full; the entry is counted in fifo_level on the next cycle.
REQ-017 SHALL drop sample_valid when full (contents unchanged) and set overflow.
REQ-018 SHALL, when enable=1, toggle i2s_bclk every CLK_DIV clk cycles using a divider counter 0..CLK_DIV-1; a "fall event" is the cycle bclk goes 1->0.
REQ-019 SHALL update bit index q_bit (0..31, wraps 31->0), i2s_lrclk and i2s_sdata only on fall events, registered in the same clk as the bclk change.
REQ-020 SHALL, on the fall event entering q_bit=0, pop one FIFO entry into a 32-bit frame word {L,R}; if the FIFO is empty, it SHALL reload the last popped word (0 after reset) and set underflow.
REQ-021 SHALL drive i2s_sdata at q_bit=k with frame_word[31-k].
REQ-022 SHALL drive i2s_lrclk to 1 for q_bit 15..30 and to 0 for q_bit 31 and 0..14 (standard I2S: one-BCLK delay of the MSB after the LRCLK edge).
REQ-023 SHALL, on a simultaneous pop and write, leave fifo_level unchanged and accept the write even when the FIFO is full at that moment.
REQ-024 SHALL, when enable=0, hold bclk/lrclk/sdata at 0, clear the divider, set q_bit=31, and keep the FIFO accepting writes; the first fall event after enable rises loads a frame (q_bit 31->0).
REQ-025 SHALL, on a simultaneous status_clr and flag set, leave the flag set (set wins).
REQ-026 SHALL have a frame period of 64*CLK_DIV clk cycles; write-to-serial latency is until the next q_bit=0 entry plus queued frames.

Reset
REQ-027 SHALL, on reset: i2s_bclk=0, i2s_lrclk=0, i2s_sdata=0, fifo_level=0, underflow=0, overflow=0, last word=0, q_bit=31, divider=0.
REQ-028 SHALL give reset asserted mid-frame priority over every other input; the FIFO contents SHALL be discarded.

Structure
REQ-029 SHALL define FRAME_BITS=32, SAMPLE_W=16 and the fifo_level width in shared package audio_pkg.
REQ-030 SHALL put the FIFO in sub-module audio_sample_fifo (32-bit data, full/empty/level, synchronous reset); the divider and serializer SHALL live in the top module.

Verification
REQ-031 SHALL cover: CLK_DIV=2, one write L=16'h8001 R=16'h7FFE, enable -> first frame sdata bits = 1000_0000_0000_0001 then 0111_1111_1111_1110; lrclk falls one BCLK before the L MSB.
REQ-032 SHALL cover: 5 writes with FIFO_DEPTH=4 and enable=0 -> fifo_level=4, overflow=1, 5th sample never serialized.
REQ-033 SHALL cover: one write 16'h1234/16'h5678 then no writes for 3 frames -> all frames repeat 1234/5678, underflow=1; status_clr -> underflow=0.
REQ-034 SHALL cover: a pop and a write in the same cycle with the FIFO full -> level stays 4, overflow stays 0.
REQ-035 SHALL cover: reset asserted at q_bit=10 -> next cycle all outputs 0, level 0; after release, the first frame is all zeros with underflow=1 if nothing is written.
REQ-036 SHALL cover: CLK_DIV=8 -> bclk period 16 clk and lrclk period 512 clk, checked over 4 frames.
